serial_sub_seq: RTL

//  Bit-serial W-bit subtraction sequencer built around the one-bit full subtractor cell.

---
 rtl/serial_sub_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_sub_seq.sv
// Bit-serial W-bit subtractor sequencer: drives one external full-subtractor cell LSB first
// and assembles diff = (a - b - bin) mod 2^W. Optional overflow output under SERIAL_SUB_OVF_EN.
module serial_sub_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         sub_a,
    output logic         sub_b,
    output logic         sub_c,
    input  logic         sub_diff,
    input  logic         sub_bout,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_sr, b_sr, res_sr;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       diff_q;
    logic               bout_q;
    logic               last_bit;

    assign last_bit = (cnt_q == CNT_W'(W - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers are updated only at the final shift edge, so diff/borrow_out stay stable
    // while the next operation is shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                    end
                end
                SHIFT: begin
                    res_sr   <= {sub_diff, res_sr[W-1:1]};
                    borrow_q <= sub_bout;
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    cnt_q    <= last_bit ? '0 : cnt_q + 1'b1;
                    if (last_bit) begin
                        diff_q <= {sub_diff, res_sr[W-1:1]};
                        bout_q <= sub_bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // Overflow is the MSB stage's borrow-in XOR its borrow-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == SHIFT && last_bit) begin
            ovf_q <= borrow_q ^ sub_bout;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign sub_a      = busy & a_sr[0];
    assign sub_b      = busy & b_sr[0];
    assign sub_c      = busy & borrow_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule
